// File: rtl/sd_bd_fifo_pkg.sv
// Shared SD controller constants for the buffer-descriptor store.
// Provides RAM word width, slot count and the words-per-descriptor helper.
package sd_bd_fifo_pkg;

   localparam int RAM_MEM_WIDTH = 32;
   localparam int BD_SIZE       = 8;
   localparam int BD_BITS       = 64;   // card block address + system memory address

   function automatic int words_per_bd(input int width);
      return BD_BITS / width;
   endfunction

   function automatic int ptr_width(input int depth, input int wpb);
      return (depth * wpb > 1) ? $clog2(depth * wpb) : 1;
   endfunction

endpackage

// File: rtl/sd_bd_fifo_ram.sv
// Simple dual-port synchronous RAM holding descriptor words.
// The read port has an enable so its registered output holds between reads.
module sd_bd_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              wb_clk_i,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_reg;

   always_ff @(posedge wb_clk_i) begin
      if (we)
         mem[waddr] <= wdata;
   end

   always_ff @(posedge wb_clk_i) begin
      if (re)
         rdata_reg <= mem[raddr];
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/sd_bd_fifo.sv
// Circular buffer-descriptor store between the Wishbone register block and
// the data-transfer master; only fully written descriptors become readable.
module sd_bd_fifo
   import sd_bd_fifo_pkg::*;
#(
   parameter int DATA_W   = RAM_MEM_WIDTH,
   parameter int BD_DEPTH = BD_SIZE,
   parameter int WPB      = words_per_bd(DATA_W)
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              we_m,
   input  logic [DATA_W-1:0] dat_in_m,
   input  logic              re_s,
   output logic [DATA_W-1:0] dat_out_s,
   output logic [7:0]        free_bd,
   output logic              new_bd,
   output logic              bd_done,
   output logic              wr_drop
);

   localparam int MEM_WORDS = BD_DEPTH * WPB;
   localparam int PTR_W     = ptr_width(BD_DEPTH, WPB);
   localparam int WC_W      = (WPB > 1) ? $clog2(WPB) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MEM_WORDS - 1);
   localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(WPB - 1);
   localparam logic [7:0]       FREE_INIT = 8'(BD_DEPTH);

   logic [PTR_W-1:0] wp_reg, wp_next;
   logic [PTR_W-1:0] rp_reg, rp_next;
   logic [WC_W-1:0]  wr_cnt_reg, wr_cnt_next;
   logic [WC_W-1:0]  rd_cnt_reg, rd_cnt_next;
   logic [7:0]       free_bd_reg, free_bd_next;
   logic             new_bd_reg, new_bd_next;
   logic             bd_done_reg, wr_drop_reg;
   logic             out_zero_reg;

   logic             wr_accept, wr_discard, commit;
   logic             rd_accept, consume;
   logic [DATA_W-1:0] ram_q;

   always_comb begin
      wr_accept    = we_m && ((free_bd_reg != 8'd0) || (wr_cnt_reg != '0));
      wr_discard   = we_m && !wr_accept;
      commit       = wr_accept && (wr_cnt_reg == WC_LAST);
      // a descriptor already being read is finished even if new_bd dropped
      rd_accept    = re_s && (new_bd_reg || (rd_cnt_reg != '0));
      consume      = rd_accept && (rd_cnt_reg == WC_LAST);

      wp_next      = wp_reg;
      wr_cnt_next  = wr_cnt_reg;
      rp_next      = rp_reg;
      rd_cnt_next  = rd_cnt_reg;
      free_bd_next = free_bd_reg;

      if (wr_accept) begin
         wp_next     = (wp_reg == PTR_LAST) ? '0 : wp_reg + 1'b1;
         wr_cnt_next = (wr_cnt_reg == WC_LAST) ? '0 : wr_cnt_reg + 1'b1;
      end
      if (rd_accept) begin
         rp_next     = (rp_reg == PTR_LAST) ? '0 : rp_reg + 1'b1;
         rd_cnt_next = (rd_cnt_reg == WC_LAST) ? '0 : rd_cnt_reg + 1'b1;
      end

      case ({commit, consume})
         2'b10:   free_bd_next = free_bd_reg - 8'd1;
         2'b01:   free_bd_next = free_bd_reg + 8'd1;
         default: free_bd_next = free_bd_reg;
      endcase
      new_bd_next = (free_bd_next != FREE_INIT);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wp_reg       <= '0;
         rp_reg       <= '0;
         wr_cnt_reg   <= '0;
         rd_cnt_reg   <= '0;
         free_bd_reg  <= FREE_INIT;
         new_bd_reg   <= 1'b0;
         bd_done_reg  <= 1'b0;
         wr_drop_reg  <= 1'b0;
         out_zero_reg <= 1'b1;
      end else begin
         wp_reg       <= wp_next;
         rp_reg       <= rp_next;
         wr_cnt_reg   <= wr_cnt_next;
         rd_cnt_reg   <= rd_cnt_next;
         free_bd_reg  <= free_bd_next;
         new_bd_reg   <= new_bd_next;
         bd_done_reg  <= consume;
         wr_drop_reg  <= wr_discard;
         if (rd_accept)
            out_zero_reg <= 1'b0;
      end
   end

   sd_bd_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (PTR_W),
      .DEPTH  (MEM_WORDS)
   ) u_ram (
      .wb_clk_i (wb_clk_i),
      .we       (wr_accept),
      .waddr    (wp_reg),
      .wdata    (dat_in_m),
      .re       (rd_accept),
      .raddr    (rp_reg),
      .rdata    (ram_q)
   );

   // RAM output has no reset, so mask it until the first read after reset
   assign dat_out_s = out_zero_reg ? '0 : ram_q;
   assign free_bd   = free_bd_reg;
   assign new_bd    = new_bd_reg;
   assign bd_done   = bd_done_reg;
   assign wr_drop   = wr_drop_reg;

endmodule

// File: tb/tb_sd_bd_fifo.sv
// Directed bench for sd_bd_fifo: 32-bit and 16-bit instances, BD_DEPTH=4,
// scoreboard queues filled on accepted writes and drained on reads.
module tb_sd_bd_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        we32 = 1'b0, re32 = 1'b0;
   logic [31:0] din32 = '0, dout32;
   logic [7:0]  free32;
   logic        new32, done32, drop32;

   logic        we16 = 1'b0, re16 = 1'b0;
   logic [15:0] din16 = '0, dout16;
   logic [7:0]  free16;
   logic        new16, done16, drop16;

   int          n_asrt = 0;
   int          n_fail = 0;
   logic [31:0] sb32 [$];
   logic [31:0] sb16 [$];
   logic [31:0] last32;

   always #5 clk = ~clk;

   sd_bd_fifo #(.DATA_W(32), .BD_DEPTH(4)) dut32 (
      .wb_clk_i (clk), .wb_rst_i (rst),
      .we_m (we32), .dat_in_m (din32), .re_s (re32), .dat_out_s (dout32),
      .free_bd (free32), .new_bd (new32), .bd_done (done32), .wr_drop (drop32)
   );

   sd_bd_fifo #(.DATA_W(16), .BD_DEPTH(4)) dut16 (
      .wb_clk_i (clk), .wb_rst_i (rst),
      .we_m (we16), .dat_in_m (din16), .re_s (re16), .dat_out_s (dout16),
      .free_bd (free16), .new_bd (new16), .bd_done (done16), .wr_drop (drop16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      sb32.delete();
      sb16.delete();
   endtask

   task automatic wr32(input logic [31:0] d, input logic exp_drop);
      we32  = 1'b1;
      din32 = d;
      tick();
      we32  = 1'b0;
      if (!exp_drop)
         sb32.push_back(d);
      chk("wr32_drop", {31'd0, drop32}, {31'd0, exp_drop});
   endtask

   task automatic rd32(input logic exp_done);
      logic [31:0] e;
      re32 = 1'b1;
      tick();
      re32 = 1'b0;
      if (sb32.size() == 0) begin
         n_asrt++;
         n_fail++;
         $error("FAIL rd32_empty: observed %h expected no read", dout32);
      end else begin
         e = sb32.pop_front();
         last32 = e;
         chk("rd32_data", dout32, e);
      end
      chk("rd32_done", {31'd0, done32}, {31'd0, exp_done});
   endtask

   task automatic wr16(input logic [15:0] d);
      we16  = 1'b1;
      din16 = d;
      tick();
      we16  = 1'b0;
      sb16.push_back({16'd0, d});
   endtask

   task automatic rd16(input logic exp_done);
      re16 = 1'b1;
      tick();
      re16 = 1'b0;
      if (sb16.size() == 0) begin
         n_asrt++;
         n_fail++;
         $error("FAIL rd16_empty: observed %h expected no read", dout16);
      end else begin
         chk("rd16_data", {16'd0, dout16}, sb16.pop_front());
      end
      chk("rd16_done", {31'd0, done16}, {31'd0, exp_done});
   endtask

   initial begin
      // reset state
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_free32", {24'd0, free32}, 32'd4);
      chk("rst_new32",  {31'd0, new32},  32'd0);
      chk("rst_dout32", dout32,          32'd0);
      chk("rst_free16", {24'd0, free16}, 32'd4);
      chk("rst_new16",  {31'd0, new16},  32'd0);
      chk("rst_dout16", {16'd0, dout16}, 32'd0);

      // single descriptor
      wr32(32'h0000_1000, 1'b0);
      chk("single_partial_new", {31'd0, new32}, 32'd0);
      chk("single_partial_free", {24'd0, free32}, 32'd4);
      wr32(32'h2000_0000, 1'b0);
      chk("single_free", {24'd0, free32}, 32'd3);
      chk("single_new",  {31'd0, new32},  32'd1);
      rd32(1'b0);
      rd32(1'b1);
      tick();
      chk("single_done_low", {31'd0, done32}, 32'd0);
      chk("single_free_after", {24'd0, free32}, 32'd4);
      chk("single_new_after",  {31'd0, new32},  32'd0);

      // fill, overflow, partial visibility
      for (int i = 0; i < 4; i++) begin
         wr32(32'hA000_0000 + 32'(i), 1'b0);
         wr32(32'hB000_0000 + 32'(i), 1'b0);
      end
      chk("full_free", {24'd0, free32}, 32'd0);
      chk("full_new",  {31'd0, new32},  32'd1);
      wr32(32'hDEAD_BEEF, 1'b1);
      tick();
      chk("drop_pulse_end", {31'd0, drop32}, 32'd0);
      chk("drop_free", {24'd0, free32}, 32'd0);
      rd32(1'b0);
      rd32(1'b1);
      chk("one_freed", {24'd0, free32}, 32'd1);
      wr32(32'h5555_0000, 1'b0);
      chk("partial_new_hold", {31'd0, new32}, 32'd1);
      chk("partial_free_hold", {24'd0, free32}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         rd32(1'b0);
         rd32(1'b1);
      end
      chk("partial_invisible", {31'd0, new32}, 32'd0);
      chk("partial_free", {24'd0, free32}, 32'd4);
      re32 = 1'b1;
      tick();
      re32 = 1'b0;
      chk("ignored_read_hold", dout32, last32);
      chk("ignored_read_done", {31'd0, done32}, 32'd0);
      wr32(32'h5555_0001, 1'b0);
      chk("complete_new",  {31'd0, new32},  32'd1);
      chk("complete_free", {24'd0, free32}, 32'd3);
      rd32(1'b0);
      rd32(1'b1);

      // wrap-around with 6 descriptors
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 3; i++) begin
            wr32(32'hC000_0000 + 32'(r * 16 + i * 2), 1'b0);
            wr32(32'hC000_0001 + 32'(r * 16 + i * 2), 1'b0);
         end
         for (int i = 0; i < 3; i++) begin
            rd32(1'b0);
            rd32(1'b1);
         end
      end
      chk("wrap_free", {24'd0, free32}, 32'd4);
      chk("wrap_new",  {31'd0, new32},  32'd0);

      // commit and consume on the same edge
      wr32(32'h1111_0000, 1'b0);
      wr32(32'h1111_0001, 1'b0);
      chk("sim_pre_free", {24'd0, free32}, 32'd3);
      we32 = 1'b1; re32 = 1'b1; din32 = 32'h2222_0000;
      sb32.push_back(din32);
      tick();
      chk("sim_rd0", dout32, sb32.pop_front());
      chk("sim_done0", {31'd0, done32}, 32'd0);
      din32 = 32'h2222_0001;
      sb32.push_back(din32);
      tick();
      we32 = 1'b0; re32 = 1'b0;
      chk("sim_rd1", dout32, sb32.pop_front());
      chk("sim_done1", {31'd0, done32}, 32'd1);
      chk("sim_free", {24'd0, free32}, 32'd3);
      chk("sim_new",  {31'd0, new32},  32'd1);
      rd32(1'b0);
      rd32(1'b1);
      chk("sim_drain_free", {24'd0, free32}, 32'd4);

      // reset mid-descriptor, 32-bit
      wr32(32'h9999_0000, 1'b0);
      do_reset();
      chk("mid_rst_free", {24'd0, free32}, 32'd4);
      chk("mid_rst_new",  {31'd0, new32},  32'd0);
      chk("mid_rst_dout", dout32,          32'd0);
      wr32(32'h7777_0000, 1'b0);
      chk("mid_rst_partial", {31'd0, new32}, 32'd0);
      wr32(32'h7777_0001, 1'b0);
      chk("mid_rst_commit", {24'd0, free32}, 32'd3);
      rd32(1'b0);
      rd32(1'b1);

      // 16-bit: four words per descriptor, low half first
      wr16(16'h1000);
      wr16(16'h0000);
      wr16(16'h0000);
      chk("w16_partial_new", {31'd0, new16}, 32'd0);
      wr16(16'h2000);
      chk("w16_new",  {31'd0, new16},  32'd1);
      chk("w16_free", {24'd0, free16}, 32'd3);
      rd16(1'b0);
      rd16(1'b0);
      rd16(1'b0);
      rd16(1'b1);
      chk("w16_free_after", {24'd0, free16}, 32'd4);

      // reset mid-descriptor, 16-bit
      wr16(16'hEEEE);
      wr16(16'hEEEF);
      do_reset();
      chk("w16_rst_free", {24'd0, free16}, 32'd4);
      for (int i = 0; i < 4; i++)
         wr16(16'h3A00 + 16'(i));
      chk("w16_rst_new", {31'd0, new16}, 32'd1);
      rd16(1'b0);
      rd16(1'b0);
      rd16(1'b0);
      rd16(1'b1);
      chk("w16_rst_final_new", {31'd0, new16}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
